// File: rtl/execute_muldiv_stage.sv
// Execute stage: single-cycle ALU plus an iterative shift-add multiplier / restoring divider.
// States: IDLE = ALU path, accepts work | RUN = one mul/div step per edge | DONE = result waits for an advance edge.
module execute_muldiv_stage #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             flush,
  input  logic             freeze,
  input  logic             in_valid,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_porta,
  input  logic [WIDTH-1:0] in_portb,
  input  logic [WIDTH-1:0] in_imm,
  input  logic             in_alusrc,
  input  logic [1:0]       fwd_sel_a,
  input  logic [1:0]       fwd_sel_b,
  input  logic [WIDTH-1:0] fwd_ex_data,
  input  logic [WIDTH-1:0] fwd_wb_data,
  input  logic [REGW-1:0]  in_rw,
  input  logic             in_regwen,
  output logic             busy,
  output logic             out_valid,
  output logic             out_regwen,
  output logic [WIDTH-1:0] out_result,
  output logic [REGW-1:0]  out_rw,
  output logic             out_divzero
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic             is_div_q, is_div_d, dz_q, dz_d, cap_regwen_q, cap_regwen_d;
  logic [REGW-1:0]  cap_rw_q, cap_rw_d;

  logic [WIDTH-1:0] res_q, res_d;
  logic [REGW-1:0]  rw_q, rw_d;
  logic             valid_q, valid_d, regwen_q, regwen_d, divz_q, divz_d;

  logic [WIDTH-1:0] op_a, op_b, fwd_b, alu_res, mul_sum;
  logic [WIDTH:0]   rem_sh, rem_sub;
  logic             adv, flush_go, is_multi;

  assign adv      = ihit & ~freeze & ~flush;
  assign flush_go = flush & ihit;
  assign is_multi = (in_op[2:1] == 2'b11);

  always_comb begin
    case (fwd_sel_a)
      2'd1:    op_a = fwd_ex_data;
      2'd2:    op_a = fwd_wb_data;
      default: op_a = in_porta;
    endcase
    case (fwd_sel_b)
      2'd1:    fwd_b = fwd_ex_data;
      2'd2:    fwd_b = fwd_wb_data;
      default: fwd_b = in_portb;
    endcase
    op_b = in_alusrc ? in_imm : fwd_b;
  end

  always_comb begin
    alu_res = '0;
    case (in_op)
      3'd0:    alu_res = op_a + op_b;
      3'd1:    alu_res = op_a - op_b;
      3'd2:    alu_res = op_a & op_b;
      3'd3:    alu_res = op_a | op_b;
      3'd4:    alu_res = op_a ^ op_b;
      3'd5:    alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      default: alu_res = '0;
    endcase
  end

  // x holds multiplicand (mul) or dividend shifting into quotient (div); acc is product or remainder.
  always_comb begin
    mul_sum = acc_q[WIDTH-1:0] + (y_q[0] ? x_q : {WIDTH{1'b0}});
    rem_sh  = {acc_q[WIDTH-1:0], x_q[WIDTH-1]};
    rem_sub = rem_sh - {1'b0, y_q};
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    x_d          = x_q;
    y_d          = y_q;
    acc_d        = acc_q;
    is_div_d     = is_div_q;
    dz_d         = dz_q;
    cap_rw_d     = cap_rw_q;
    cap_regwen_d = cap_regwen_q;
    res_d        = res_q;
    rw_d         = rw_q;
    valid_d      = valid_q;
    regwen_d     = regwen_q;
    divz_d       = divz_q;

    case (state_q)
      IDLE: begin
        if (adv && in_valid && is_multi) begin
          state_d      = RUN;
          cnt_d        = '0;
          x_d          = op_a;
          y_d          = op_b;
          acc_d        = '0;
          is_div_d     = in_op[0];
          dz_d         = in_op[0] && (op_b == '0);
          cap_rw_d     = in_rw;
          cap_regwen_d = in_regwen;
          {res_d, rw_d, valid_d, regwen_d, divz_d} = '0;
        end else if (adv) begin
          res_d    = alu_res;
          rw_d     = in_rw;
          valid_d  = in_valid;
          regwen_d = in_regwen;
          divz_d   = 1'b0;
        end
      end
      RUN: begin
        x_d = {x_q[WIDTH-2:0], 1'b0};
        if (is_div_q) begin
          if (rem_sh >= {1'b0, y_q}) begin
            acc_d  = rem_sub;
            x_d[0] = 1'b1;
          end else begin
            acc_d = rem_sh;
          end
        end else begin
          acc_d = {1'b0, mul_sum};
          y_d   = y_q >> 1;
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) state_d = DONE;
        if (adv) {res_d, rw_d, valid_d, regwen_d, divz_d} = '0;
      end
      DONE: begin
        if (adv) begin
          res_d    = is_div_q ? x_q : acc_q[WIDTH-1:0];
          rw_d     = cap_rw_q;
          valid_d  = 1'b1;
          regwen_d = cap_regwen_q;
          divz_d   = dz_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush_go) begin
      state_d = IDLE;
      cnt_d   = '0;
      {x_d, y_d, acc_d, is_div_d, dz_d, cap_rw_d, cap_regwen_d} = '0;
      {res_d, rw_d, valid_d, regwen_d, divz_d} = '0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      acc_q        <= '0;
      is_div_q     <= 1'b0;
      dz_q         <= 1'b0;
      cap_rw_q     <= '0;
      cap_regwen_q <= 1'b0;
      res_q        <= '0;
      rw_q         <= '0;
      valid_q      <= 1'b0;
      regwen_q     <= 1'b0;
      divz_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      x_q          <= x_d;
      y_q          <= y_d;
      acc_q        <= acc_d;
      is_div_q     <= is_div_d;
      dz_q         <= dz_d;
      cap_rw_q     <= cap_rw_d;
      cap_regwen_q <= cap_regwen_d;
      res_q        <= res_d;
      rw_q         <= rw_d;
      valid_q      <= valid_d;
      regwen_q     <= regwen_d;
      divz_q       <= divz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign out_valid   = valid_q;
  assign out_regwen  = regwen_q;
  assign out_result  = res_q;
  assign out_rw      = rw_q;
  assign out_divzero = divz_q;
endmodule

// File: tb/tb_execute_muldiv_stage.sv
// Bench for execute_muldiv_stage: directed scenarios, then randomized traffic against a transaction-level model.
module tb_execute_muldiv_stage;
  logic        CLK, nRST, ihit, flush, freeze, in_valid, in_alusrc, in_regwen;
  logic [2:0]  in_op;
  logic [31:0] in_porta, in_portb, in_imm, fwd_ex_data, fwd_wb_data;
  logic [1:0]  fwd_sel_a, fwd_sel_b;
  logic [4:0]  in_rw;
  logic        busy, out_valid, out_regwen, out_divzero;
  logic [31:0] out_result;
  logic [4:0]  out_rw;

  int n_tests = 0;
  int n_fail  = 0;

  execute_muldiv_stage #(.WIDTH(32), .REGW(5)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .flush(flush), .freeze(freeze),
    .in_valid(in_valid), .in_op(in_op), .in_porta(in_porta), .in_portb(in_portb),
    .in_imm(in_imm), .in_alusrc(in_alusrc), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .fwd_ex_data(fwd_ex_data), .fwd_wb_data(fwd_wb_data), .in_rw(in_rw),
    .in_regwen(in_regwen), .busy(busy), .out_valid(out_valid), .out_regwen(out_regwen),
    .out_result(out_result), .out_rw(out_rw), .out_divzero(out_divzero)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: return a * b;
      default: return (b == 0) ? 32'hFFFF_FFFF : a / b;
    endcase
  endfunction

  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] reg_v);
    if (sel == 2'd1) return fwd_ex_data;
    if (sel == 2'd2) return fwd_wb_data;
    return reg_v;
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1; in_op = op; in_porta = a; in_portb = b;
    in_alusrc = 1'b0; fwd_sel_a = 2'd0; fwd_sel_b = 2'd0;
    in_rw = 5'd9; in_regwen = 1'b1; ihit = 1'b1; freeze = 1'b0; flush = 1'b0;
  endtask

  task automatic idle_in();
    in_valid = 1'b0; in_op = 3'd0;
  endtask

  task automatic scramble();
    in_valid = 1'b1; in_op = 3'($urandom); in_porta = $urandom; in_portb = $urandom;
    in_rw = 5'($urandom);
  endtask

  // Full unobstructed multicycle op: accept at edge 0, result visible after edge 33.
  task automatic mc(input string tag, input logic [2:0] op, input logic [31:0] a,
                    input logic [31:0] b, input logic [31:0] exp, input logic dz);
    issue(op, a, b);
    step();
    chk({tag, " busy after accept"}, busy, 1);
    chk({tag, " bubble after accept"}, out_valid, 0);
    scramble();
    for (int e = 1; e <= 32; e++) begin
      step();
      if (e == 16 || e == 32) begin
        chk({tag, " busy while running"}, busy, 1);
        chk({tag, " bubble while running"}, out_valid, 0);
      end
    end
    step();
    idle_in();
    chk({tag, " result"}, out_result, exp);
    chk({tag, " valid"}, out_valid, 1);
    chk({tag, " rw"}, out_rw, 9);
    chk({tag, " divzero"}, out_divzero, dz);
    chk({tag, " busy falls"}, busy, 0);
  endtask

  logic [31:0] m_res, p_res, a_v, b_v;
  logic [4:0]  m_rw, p_rw;
  logic        m_valid, m_regwen, m_dz, p_dz, p_regwen, m_busy, adv;
  int          m_left;

  initial begin
    nRST = 1'b0; ihit = 1'b0; flush = 1'b0; freeze = 1'b0; in_valid = 1'b0;
    in_op = 3'd0; in_porta = '0; in_portb = '0; in_imm = '0; in_alusrc = 1'b0;
    fwd_sel_a = 2'd0; fwd_sel_b = 2'd0; fwd_ex_data = '0; fwd_wb_data = '0;
    in_rw = '0; in_regwen = 1'b0;
    #1;
    chk("reset busy", busy, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset out_result", out_result, 0);
    #22 nRST = 1'b1;
    step();

    issue(3'd0, 32'hFFFF_FFFF, 32'd1);
    step();
    chk("add wrap result", out_result, 0);
    chk("add wrap valid", out_valid, 1);
    chk("add wrap rw", out_rw, 9);

    issue(3'd5, 32'hFFFF_FFFF, 32'd1);
    step();
    chk("slt signed", out_result, 1);
    issue(3'd0, 32'd2, 32'd100);
    in_alusrc = 1'b1; in_imm = 32'd5; fwd_sel_b = 2'd1; fwd_ex_data = 32'd9;
    step();
    chk("imm overrides fwd", out_result, 7);

    mc("mul", 3'd6, 32'h0001_0000, 32'h0001_0003, 32'h0003_0000, 1'b0);
    mc("divu", 3'd7, 32'd100, 32'd7, 32'd14, 1'b0);
    mc("divu0", 3'd7, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);

    issue(3'd6, 32'd1234, 32'd5678);
    step();
    scramble();
    for (int e = 1; e <= 9; e++) step();
    flush = 1'b1; ihit = 1'b1;
    step();
    chk("flush zero latch", out_result, 0);
    chk("flush valid", out_valid, 0);
    chk("flush busy", busy, 0);
    issue(3'd0, 32'd3, 32'd4);
    step();
    chk("add after flush", out_result, 7);

    issue(3'd7, 32'd100, 32'd7);
    step();
    scramble();
    for (int e = 1; e <= 29; e++) step();
    freeze = 1'b1;
    for (int e = 30; e <= 40; e++) step();
    chk("frozen done busy", busy, 1);
    chk("frozen done valid", out_valid, 0);
    freeze = 1'b0;
    step();
    idle_in();
    chk("unfrozen result", out_result, 14);
    chk("unfrozen valid", out_valid, 1);
    chk("unfrozen busy", busy, 0);

    issue(3'd6, 32'd77, 32'd88);
    step();
    idle_in();
    for (int e = 1; e <= 5; e++) step();
    #2 nRST = 1'b0;
    #1;
    chk("mid-run reset busy", busy, 0);
    chk("mid-run reset valid", out_valid, 0);
    chk("mid-run reset result", out_result, 0);
    @(negedge CLK);
    nRST = 1'b1;
    issue(3'd1, 32'd10, 32'd3);
    step();
    chk("sub after reset", out_result, 7);
    chk("sub after reset busy", busy, 0);

    // Random traffic from a clean reset so the model starts from all-zero outputs.
    nRST = 1'b0;
    #3 nRST = 1'b1;
    {m_res, m_rw, m_valid, m_regwen, m_dz, m_busy} = '0;
    m_left = 0;
    for (int i = 0; i < 2500; i++) begin
      ihit = ($urandom % 4) != 0;
      freeze = ($urandom % 4) == 0;
      flush = ($urandom % 30) == 0;
      in_valid = ($urandom % 3) != 0;
      in_op = 3'($urandom);
      if (!in_valid && in_op >= 3'd6) in_op = 3'($urandom % 6);
      in_porta = $urandom;
      in_portb = ($urandom % 2) ? $urandom : ($urandom % 8);
      in_imm = ($urandom % 2) ? $urandom : ($urandom % 8);
      in_alusrc = 1'($urandom);
      fwd_sel_a = 2'($urandom); fwd_sel_b = 2'($urandom);
      fwd_ex_data = $urandom; fwd_wb_data = $urandom % 16;
      in_rw = 5'($urandom); in_regwen = 1'($urandom);

      a_v = fwd(fwd_sel_a, in_porta);
      b_v = in_alusrc ? in_imm : fwd(fwd_sel_b, in_portb);
      adv = ihit && !freeze && !flush;
      if (flush && ihit) begin
        {m_res, m_rw, m_valid, m_regwen, m_dz, m_busy} = '0;
      end else if (m_busy) begin
        if (m_left > 0) begin
          m_left--;
          if (adv) {m_res, m_rw, m_valid, m_regwen, m_dz} = '0;
        end else if (adv) begin
          m_res = p_res; m_rw = p_rw; m_regwen = p_regwen; m_dz = p_dz;
          m_valid = 1'b1; m_busy = 1'b0;
        end
      end else if (adv) begin
        if (in_valid && in_op >= 3'd6) begin
          p_res = ref_res(in_op, a_v, b_v);
          p_dz = (in_op == 3'd7) && (b_v == 0);
          p_rw = in_rw; p_regwen = in_regwen;
          m_busy = 1'b1; m_left = 32;
          {m_res, m_rw, m_valid, m_regwen, m_dz} = '0;
        end else begin
          m_res = ref_res(in_op, a_v, b_v); m_rw = in_rw; m_regwen = in_regwen;
          m_valid = in_valid; m_dz = 1'b0;
        end
      end
      step();
      chk("rand result", out_result, m_res);
      chk("rand valid", out_valid, m_valid);
      chk("rand rw", out_rw, m_rw);
      chk("rand regwen", out_regwen, m_regwen);
      chk("rand divzero", out_divzero, m_dz);
      chk("rand busy", busy, m_busy);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
